ext_arbiter: RTL
================

# ext_arbiter

Shares the single combinational `sign_extender` (24-bit immediate in, 32-bit out, `signop` selects sign/zero extension) between two requesters: decode immediate (port 0) and branch-target (port 1). Arbitrates round-robin, applies `signop` per request, and returns the extended value through a one-entry registered response buffer with valid/ready backpressure. Sits between the decode stage and the ALU/PC-update logic.

## Interface
- `NREQ`, 2: number of requesters, fixed at 2 in this revision.
- `IN_W`, 24: immediate width into the extender.
- `OUT_W`, 32: extended width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  request valid, one bit per requester.
- `req_ready`  out  2  request accepted this cycle (one-hot or zero).
- `req_imm0`, `req_imm1`  in  24  immediate field per requester.
- `req_signop`  in  2  per requester: 1 = sign-extend from bit 23, 0 = zero-extend.
- `rsp_valid`  out  1  response buffer holds data.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  32  extended value.
- `rsp_id`  out  1  requester that owns `rsp_data`.
- `grant_cnt0`, `grant_cnt1`  out  16  accepted-request counters per requester, wrap at 0xFFFF→0.

## Operation
- States: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- A cycle is accept-capable when the state is EMPTY, or FULL with `rsp_ready`=1 (drain and refill in the same cycle).
- On an accept-capable cycle with any `req_valid`:
  - Grant one requester and assert its `req_ready`.
  - Drive that requester's `req_imm`/`req_signop` into the shared extender.
  - Register the extender output into `rsp_data` and the index into `rsp_id`.
  - Increment the granted counter. Next state is FULL.
- Arbitration: round-robin pointer `last`.
  - Both valid → grant `~last`.
  - One valid → grant it.
  - `last` updates only on a grant. Reset value of `last` = 1, so requester 0 wins the first contention.
- FULL with `rsp_ready`=0: hold `rsp_data`/`rsp_id`; `req_ready`=0; pointer and counters unchanged.
- FULL with `rsp_ready`=1 and no `req_valid`: next state is EMPTY. `rsp_data` holds its last value (don't-care while invalid).
- `req_ready` is a combinational function of `req_valid`, `last`, state and `rsp_ready`. It never depends on `req_imm`.
- Extension rule:
  - `signop`=1 → out = {8{in[23]}, in}.
  - `signop`=0 → out = {8'h00, in}.
- Requesters must hold `req_*` stable while `req_valid`=1 and `req_ready`=0. The block does not check this.

## Timing
- Latency: request accepted at edge N → `rsp_valid`=1 with data after edge N (visible in cycle N+1).
- Throughput: one response per cycle while `rsp_ready`=1.
- Reset (synchronous, edge where `reset`=1), regardless of state or pending handshake:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `req_ready`=0 in the reset cycle.
  - `last`=1, `grant_cnt0`=`grant_cnt1`=0.
  - Any in-flight response is discarded.
- Counter wrap: increment at 0xFFFF gives 0x0000, with no saturation.
- Simultaneous drain and accept in FULL: the new data replaces the old in one edge. `rsp_valid` stays 1 with no bubble.

## Structure
- Shared package `ext_pkg`: `IN_W`, `OUT_W` constants, the `SIGNOP_SIGN`/`SIGNOP_ZERO` encodings, and the 1-bit requester id type.
- Sub-module: the existing `sign_extender`, instantiated once, unmodified.
- Round-robin pick logic is a local function, not a separate module.

## Test plan
- Single request: port0 `imm`=0xFF2609, `signop`=1, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_data`=0xFFFF2609, `rsp_id`=0. Repeat with `signop`=0 → 0x00FF2609.
- Contention: both ports valid every cycle (port0 0x000001, port1 0x800000 with `signop`=1), `rsp_ready`=1 → `rsp_id` alternates 0,1,0,1. Port1 responses = 0xFF800000. Counters increase equally.
- Backpressure: fill the buffer, hold `rsp_ready`=0 for 5 cycles with both ports valid → `req_ready`=0, `rsp_data` stable, counters frozen. Release → that cycle drains and accepts; the next `rsp_id` follows the round-robin order.
- Reset mid-operation: assert `reset` while FULL and stalled → next cycle `rsp_valid`=0, counters 0. The first contention after reset grants port0.
- Counter wrap: preload by issuing 65535 grants to port0, then one more → `grant_cnt0`=0x0000. `grant_cnt1` is unaffected.
- Idle drain: one response, then `rsp_ready`=1 with no requests → `rsp_valid` drops after one edge and `req_ready` stays 0 until `req_valid` is asserted.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared constants and types for the sign-extender arbiter slice.
package ext_pkg;
  localparam int IN_W  = 24;
  localparam int OUT_W = 32;
  localparam int CNT_W = 16;

  localparam logic SIGNOP_SIGN = 1'b1;
  localparam logic SIGNOP_ZERO = 1'b0;

  typedef logic req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;
endpackage

// File: rtl/sign_extender.sv
// Combinational immediate extender: sign- or zero-extends IN_W bits to OUT_W bits.
module sign_extender
  import ext_pkg::*;
(
  input  logic [IN_W-1:0]  imm_in,
  input  logic             signop,
  output logic [OUT_W-1:0] ext_out
);

  assign ext_out = (signop == SIGNOP_SIGN) ? {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in}
                                           : {{(OUT_W-IN_W){1'b0}}, imm_in};

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin share of one sign_extender between two requesters; one-entry registered
// response buffer, result visible the cycle after accept, refills while draining.
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [IN_W-1:0]  req_imm0,
  input  logic [IN_W-1:0]  req_imm1,
  input  logic [NREQ-1:0]  req_signop,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output req_id_t          rsp_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  // Contention goes to whoever did not win last; a lone requester always wins.
  function automatic req_id_t rr_pick(input logic [NREQ-1:0] valid, input req_id_t last);
    if (&valid) begin
      return ~last;
    end else if (valid[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  rsp_state_e       state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  req_id_t          id_q, id_d;
  req_id_t          last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             accept;
  req_id_t          gnt_id;
  logic [IN_W-1:0]  ext_imm;
  logic             ext_signop;
  logic [OUT_W-1:0] ext_out;

  always_comb begin
    accept     = !reset && ((state_q == ST_EMPTY) || rsp_ready) && (|req_valid);
    gnt_id     = rr_pick(req_valid, last_q);
    ext_imm    = gnt_id ? req_imm1 : req_imm0;
    ext_signop = req_signop[gnt_id];
    req_ready  = '0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  sign_extender u_sign_extender (
    .imm_in  (ext_imm),
    .signop  (ext_signop),
    .ext_out (ext_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = ext_out;
      id_d    = gnt_id;
      last_d  = gnt_id;
      if (gnt_id) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_data   = data_q;
  assign rsp_id     = id_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule
